// File: rtl/arb_rr.sv
// N-requester round-robin arbiter with registered one-hot grant, owner ID and grant hold.
// Define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when others are waiting.
module arb_rr #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    request,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            busy
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [N-1:0]    cand;
    logic [N-1:0]    win_oh;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] nxt_ptr;
    logic            found;
    logic            owner_req;
    logic            preempt;
    logic            keep;
    int              idx;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt;

    // The current cycle counts toward the hold, so preemption lands exactly MAX_HOLD cycles after the grant.
    assign preempt = (state == OWNED) && ((int'(hold_cnt) + 1) >= MAX_HOLD)
                     && (|(request & ~grant));
`else
    assign preempt = 1'b0;
`endif

    assign owner_req = |(request & grant);
    assign keep      = (state == OWNED) && owner_req && !preempt;
    assign cand      = preempt ? (request & ~grant) : request;

    // Rotating scan starting at ptr; index wraps modulo N so non-power-of-2 N is handled.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        win_oh = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && cand[idx]) begin
                found       = 1'b1;
                win         = ID_W'(idx);
                win_oh[idx] = 1'b1;
            end
        end
        nxt_ptr = (int'(win) == N - 1) ? '0 : win + ID_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else if (keep) begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt != CNT_W'(MAX_HOLD)) hold_cnt <= hold_cnt + CNT_W'(1);
`endif
        end else if (found) begin
            state    <= OWNED;
            grant    <= win_oh;
            grant_id <= win;
            busy     <= 1'b1;
            ptr      <= nxt_ptr;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end
    end

endmodule
